// File: rtl/rank_sorter_if.sv
// rtl/rank_sorter_if.sv - handshake bundle between the sample front-end, rank_sorter and the filter output stage
//
// Signals:
//   in_valid_i / in_ready_o   input vector handshake
//   numbers_i                 packed input vector, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rank_i, descending_i      per-vector rank select and sort order
//   out_valid_o / out_ready_i result handshake
//   numbers_o, rank_o         sorted vector and selected element
//   busy_o                    high while sorting
// Modports: slave = the sorter, master = the block feeding and draining it.
interface rank_sorter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_SIZE  = 9,
   parameter int RW         = $clog2(DATA_SIZE)
);
   logic                            in_valid_i;
   logic                            in_ready_o;
   logic [DATA_SIZE*DATA_WIDTH-1:0] numbers_i;
   logic [RW-1:0]                   rank_i;
   logic                            descending_i;
   logic                            out_valid_o;
   logic                            out_ready_i;
   logic [DATA_SIZE*DATA_WIDTH-1:0] numbers_o;
   logic [DATA_WIDTH-1:0]           rank_o;
   logic                            busy_o;

   modport slave (
      input  in_valid_i, numbers_i, rank_i, descending_i, out_ready_i,
      output in_ready_o, out_valid_o, numbers_o, rank_o, busy_o
   );

   modport master (
      output in_valid_i, numbers_i, rank_i, descending_i, out_ready_i,
      input  in_ready_o, out_valid_o, numbers_o, rank_o, busy_o
   );
endinterface

// File: rtl/rank_sorter.sv
// rtl/rank_sorter.sv - odd-even transposition sorter returning the sorted vector and a selected rank
//
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_i   synchronous active-high reset; aborts any sort in progress
//   bus     rank_sorter_if.slave: input vector handshake, result handshake, busy
// One compare/swap pass per cycle while in SORT; outputs are registered and
// only change on entry to DONE.
module rank_sorter #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_SIZE  = 9,
   parameter int SIGNED     = 0,
   parameter int EARLY_EXIT = 0,
   parameter int RW         = $clog2(DATA_SIZE)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   rank_sorter_if.slave bus
);
   localparam int CW = $clog2(DATA_SIZE + 1);

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                          state;
   logic [DATA_WIDTH-1:0]           arr [DATA_SIZE];
   logic [DATA_WIDTH-1:0]           nxt [DATA_SIZE];
   logic [DATA_SIZE*DATA_WIDTH-1:0] nxt_flat;
   logic [CW-1:0]                   cnt;
   logic [RW-1:0]                   rank_q;
   logic [RW-1:0]                   rank_clamped;
   logic                            desc_q;
   logic                            prev_clean;
   logic                            any_swap;
   logic                            last_pass;
   logic                            in_ready_q;
   logic                            out_valid_q;
   logic                            busy_q;
   logic [DATA_SIZE*DATA_WIDTH-1:0] numbers_q;
   logic [DATA_WIDTH-1:0]           rank_out_q;

   function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      else             return a > b;
   endfunction

   // cnt = passes already done, so the current pass is cnt+1: an odd pass
   // (cnt even) starts its pairs at index 0, an even pass at index 1.
   always_comb begin
      nxt      = arr;
      any_swap = 1'b0;
      for (int i = 0; i < DATA_SIZE - 1; i++) begin
         if (i[0] == cnt[0]) begin
            if (desc_q ? gt(arr[i+1], arr[i]) : gt(arr[i], arr[i+1])) begin
               nxt[i]   = arr[i+1];
               nxt[i+1] = arr[i];
               any_swap = 1'b1;
            end
         end
      end
   end

   always_comb begin
      nxt_flat = '0;
      for (int k = 0; k < DATA_SIZE; k++) nxt_flat[k*DATA_WIDTH +: DATA_WIDTH] = nxt[k];
   end

   // prev_clean is cleared on capture, so early exit needs two clean passes.
   assign last_pass = (cnt == CW'(DATA_SIZE - 1)) ||
                      ((EARLY_EXIT != 0) && prev_clean && !any_swap);

   assign rank_clamped = ({1'b0, bus.rank_i} >= (RW+1)'(DATA_SIZE)) ? RW'(DATA_SIZE - 1) : bus.rank_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         numbers_q   <= '0;
         rank_out_q  <= '0;
         cnt         <= '0;
         rank_q      <= '0;
         desc_q      <= 1'b0;
         prev_clean  <= 1'b0;
         for (int k = 0; k < DATA_SIZE; k++) arr[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid_i && in_ready_q) begin
                  for (int k = 0; k < DATA_SIZE; k++) arr[k] <= bus.numbers_i[k*DATA_WIDTH +: DATA_WIDTH];
                  rank_q     <= rank_clamped;
                  desc_q     <= bus.descending_i;
                  cnt        <= '0;
                  prev_clean <= 1'b0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= SORT;
               end
            end
            SORT: begin
               arr        <= nxt;
               cnt        <= cnt + 1'b1;
               prev_clean <= !any_swap;
               if (last_pass) begin
                  numbers_q   <= nxt_flat;
                  rank_out_q  <= nxt[rank_q];
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               // in_ready stays low this cycle so a result and a new vector never share an edge.
               if (bus.out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.busy_o      = busy_q;
   assign bus.numbers_o   = numbers_q;
   assign bus.rank_o      = rank_out_q;
endmodule
